// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter library.
// Holds the down-counter state encoding and the default WIDTH/PRESCALE values.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH    = 4;
  localparam int DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/down_prescaler.sv
// Free-running 0..PRESCALE-1 divider that emits a one-cycle tick on its wrap cycle.
// Only built into sync_down_counter when PRESCALE_EN is defined.
module down_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pre_reg <= '0;
    end else if (pre_reg == LAST) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_reg + PW'(1);
    end
  end

  assign tick = (pre_reg == LAST);

endmodule

// File: rtl/sync_down_counter.sv
// Loadable down-counter/timer with one-shot or periodic reload and a terminal-count pulse.
// Optional macro PRESCALE_EN: decrement/reload only every PRESCALE clock cycles.
module sync_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("sync_down_counter: PRESCALE must be >= 1");
  end

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc_reg, tc_next;
  logic             tick;

`ifdef PRESCALE_EN
  down_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (load | start | stop),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
    end else begin
      count_reg  <= count_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
    end
  end

  // Strobe priority: load > stop > start > decrement. A start with an empty
  // reload register is treated as if it were absent.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    if (load) begin
      reload_next = load_val;
      count_next  = load_val;
      if (state_reg == DONE) begin
        state_next = IDLE;
      end
    end else if (stop) begin
      state_next = IDLE;
    end else if (start && (reload_reg != '0)) begin
      count_next = reload_reg;
      state_next = RUN;
    end else if ((state_reg == RUN) && tick) begin
      if (count_reg == '0) begin
        if (auto_reload) begin
          count_next = reload_reg;
        end else begin
          state_next = DONE;
        end
      end else begin
        count_next = count_reg - WIDTH'(1);
        if (count_reg == WIDTH'(1)) begin
          tc_next = 1'b1;
          if (!auto_reload) begin
            state_next = DONE;
          end
        end
      end
    end
  end

  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  assign count = count_reg;
  assign tc    = tc_reg;

endmodule
